// File: rtl/uart_pkg.sv
// Shared UART types: byte type, word-packer FSM states and the default frame header byte.
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } packer_state_e;

    localparam byte_t UART_SYNC_BYTE = 8'hA5;

    // A byte index needs at least one bit, even for single-byte words.
    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO: the head word is on rd_data whenever empty is low.
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          full_q;
    logic          do_push;
    logic          do_pop;

    // A push while full is dropped even if a pop happens in the same cycle.
    assign do_push = push & ~full_q;
    assign do_pop  = pop & (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = full_q;
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/uart_tx_word_packer.sv
// Buffers result words and serialises each as an optional SYNC byte plus its data bytes,
// LSB first, onto a valid/ready byte stream feeding the UART transmitter.
module uart_tx_word_packer
    import uart_pkg::*;
#(
    parameter int          WORD_W    = 32,
    parameter int          DEPTH     = 8,
    parameter int          SYNC_EN   = 1,
    parameter logic [7:0]  SYNC_BYTE = UART_SYNC_BYTE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WORD_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);

    localparam int NBYTES = WORD_W / 8;
    localparam int IDX_W  = idx_width(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic [WORD_W-1:0] fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    packer_state_e     state_q;
    packer_state_e     state_d;

    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] load_val;
    logic              load_word;
    logic              shift_en;
    logic [IDX_W-1:0]  byte_idx;
    logic [IDX_W-1:0]  byte_idx_d;
    logic [7:0]        out_data_d;
    logic              out_valid_d;
    logic              xfer;
    logic              last_byte;

    sync_fifo #(
        .W     (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_valid),
        .wr_data (in_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign in_ready  = ~fifo_full;
    assign xfer      = out_valid & out_ready;
    assign last_byte = (byte_idx == LAST_IDX);
    assign busy      = ~fifo_empty | (state_q != IDLE);

    // Without a header the first data byte leaves on the pop, so the shifter starts one byte on.
    assign load_val  = (SYNC_EN != 0) ? fifo_rd_data : (fifo_rd_data >> 8);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = (SYNC_EN != 0) ? SYNC : DATA;
                end
            end
            SYNC: begin
                if (xfer) state_d = DATA;
            end
            DATA: begin
                if (xfer && last_byte) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid;
        out_data_d  = out_data;
        byte_idx_d  = byte_idx;
        load_word   = 1'b0;
        shift_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    out_valid_d = 1'b1;
                    byte_idx_d  = '0;
                    load_word   = 1'b1;
                    out_data_d  = (SYNC_EN != 0) ? SYNC_BYTE : fifo_rd_data[7:0];
                end
            end
            SYNC: begin
                if (xfer) begin
                    out_data_d = shift_q[7:0];
                    shift_en   = 1'b1;
                end
            end
            DATA: begin
                if (xfer) begin
                    if (last_byte) begin
                        out_valid_d = 1'b0;
                    end else begin
                        byte_idx_d = byte_idx + 1'b1;
                        out_data_d = shift_q[7:0];
                        shift_en   = 1'b1;
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Output stage: byte and valid are registered so they hold steady under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            byte_idx  <= '0;
        end else begin
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            byte_idx  <= byte_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_word)     shift_q <= load_val;
        else if (shift_en) shift_q <= shift_q >> 8;
    end

endmodule

// File: tb/tb_uart_tx_word_packer.sv
// Directed bench for uart_tx_word_packer: framing, latency, backpressure, FIFO fill,
// a 16-bit no-header variant, and a serial-line loop through a UART tx/rx model.
module tb_uart_tx_word_packer;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    wire         out_ready;
    logic [3:0]  fifo_count;
    logic        busy;
    logic        man_ready;
    logic        use_uart;
    logic        tx_ready;

    logic [15:0] in_data16;
    logic        in_valid16;
    logic        in_ready16;
    logic [7:0]  out_data16;
    logic        out_valid16;
    logic        out_ready16;
    logic [3:0]  fifo_count16;
    logic        busy16;

    assign out_ready = use_uart ? tx_ready : man_ready;

    uart_tx_word_packer u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    uart_tx_word_packer #(
        .WORD_W  (16),
        .SYNC_EN (0)
    ) u_dut16 (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data16),
        .in_valid   (in_valid16),
        .in_ready   (in_ready16),
        .out_data   (out_data16),
        .out_valid  (out_valid16),
        .out_ready  (out_ready16),
        .fifo_count (fifo_count16),
        .busy       (busy16)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    byte_t mon_q[$];
    byte_t mon16_q[$];
    byte_t rx_q[$];
    byte_t exp_q[$];

    always @(negedge clk) begin
        if (out_valid && out_ready)     mon_q.push_back(out_data);
        if (out_valid16 && out_ready16) mon16_q.push_back(out_data16);
    end

    // UART transmitter model, 4 clocks per bit, 8N1
    logic       tx_busy;
    logic       tx_line;
    logic [9:0] tx_sh;
    int         tx_clk;
    int         tx_bit;
    assign tx_ready = ~tx_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_busy <= 1'b0;
            tx_line <= 1'b1;
            tx_sh   <= '1;
            tx_clk  <= 0;
            tx_bit  <= 0;
        end else if (!tx_busy) begin
            if (use_uart && out_valid) begin
                tx_sh   <= {1'b1, out_data, 1'b0};
                tx_busy <= 1'b1;
                tx_line <= 1'b0;
                tx_clk  <= 0;
                tx_bit  <= 0;
            end
        end else if (tx_clk == 3) begin
            tx_clk <= 0;
            if (tx_bit == 9) begin
                tx_busy <= 1'b0;
                tx_line <= 1'b1;
            end else begin
                tx_bit  <= tx_bit + 1;
                tx_line <= tx_sh[tx_bit+1];
            end
        end else begin
            tx_clk <= tx_clk + 1;
        end
    end

    // UART receiver model: mid-bit sampling; a byte that overlaps a reset is discarded
    initial begin : rx_proc
        logic  bad;
        byte_t b;
        forever begin
            @(negedge tx_line);
            bad = 1'b0;
            b   = '0;
            repeat (2) begin @(posedge clk); #1; if (rst) bad = 1'b1; end
            if (tx_line) bad = 1'b1;
            for (int i = 0; i < 8; i++) begin
                repeat (4) begin @(posedge clk); #1; if (rst) bad = 1'b1; end
                b[i] = tx_line;
            end
            repeat (4) begin @(posedge clk); #1; if (rst) bad = 1'b1; end
            if (!tx_line) bad = 1'b1;
            if (!bad) rx_q.push_back(b);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which: 0 = main byte stream, 1 = 16-bit stream, 2 = decoded serial line
    task automatic cmp_stream(input string tag, input int which, input int base);
        int         sz;
        logic [7:0] g;
        sz = (which == 0) ? mon_q.size() : (which == 1) ? mon16_q.size() : rx_q.size();
        chk({tag, "_len"}, 64'(sz - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            g = 'x;
            if (base + i < sz) begin
                if (which == 0)      g = mon_q[base+i];
                else if (which == 1) g = mon16_q[base+i];
                else                 g = rx_q[base+i];
            end
            chk($sformatf("%s_b%0d", tag, i), 64'(g), 64'(exp_q[i]));
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        int n;
        n        = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 40) begin tick(); n++; end
        chk("push_handshake", 64'(n < 40), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (busy && n < max_cycles) begin tick(); n++; end
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int    base;
        int    base_rx;
        int    n;
        logic  found;
        logic [31:0] w;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; man_ready = 1'b1; use_uart = 1'b0;
        in_valid16 = 1'b0; in_data16 = '0; out_ready16 = 1'b1;
        tick(); tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'h00);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_fifo_count", 64'(fifo_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick();

        // single word, ready always high
        base = mon_q.size();
        in_data = 32'h1122_3344; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_t1_valid", 64'(out_valid), 64'd0);
        chk("lat_t1_busy", 64'(busy), 64'd1);
        tick();
        chk("lat_t2_valid", 64'(out_valid), 64'd1);
        chk("lat_t2_data", 64'(out_data), 64'hA5);
        wait_idle("single", 50);
        exp_q = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11};
        cmp_stream("single", 0, base);

        // backpressure on byte 33
        base = mon_q.size();
        in_data = 32'h1122_3344; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (out_valid && out_data == 8'h33) found = 1'b1;
        end
        man_ready = 1'b0;
        chk("bp_reached_33", 64'(found), 64'd1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp_hold_valid_%0d", c), 64'(out_valid), 64'd1);
            chk($sformatf("bp_hold_data_%0d", c), 64'(out_data), 64'h33);
        end
        man_ready = 1'b1;
        wait_idle("bp", 50);
        exp_q = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11};
        cmp_stream("bp", 0, base);

        // fill: one word goes into the shifter, eight fill the FIFO
        man_ready = 1'b0;
        base = mon_q.size();
        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            w = 32'h1020_3040 + 32'(i) * 32'h0101_0101;
            push_word(w);
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'(8'h40 + i));
            exp_q.push_back(8'(8'h30 + i));
            exp_q.push_back(8'(8'h20 + i));
            exp_q.push_back(8'(8'h10 + i));
        end
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        chk("fill_count", 64'(fifo_count), 64'd8);
        chk("fill_out_valid", 64'(out_valid), 64'd1);
        chk("fill_out_data", 64'(out_data), 64'hA5);
        in_data = 32'hFFFF_FFFF; in_valid = 1'b1;
        repeat (3) tick();
        chk("full_no_push_count", 64'(fifo_count), 64'd8);
        chk("full_no_push_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        man_ready = 1'b1;
        wait_idle("fill", 400);
        chk("fill_drain_ready", 64'(in_ready), 64'd1);
        chk("fill_drain_count", 64'(fifo_count), 64'd0);
        cmp_stream("fill", 0, base);

        // 16-bit word, no header
        base = mon16_q.size();
        in_data16 = 16'hBEEF; in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        n = 0;
        while (busy16 && n < 50) begin tick(); n++; end
        chk("w16_idle", 64'(busy16), 64'd0);
        exp_q = '{8'hEF, 8'hBE};
        cmp_stream("w16", 1, base);

        // serial loop through the UART models
        use_uart = 1'b1;
        base_rx = rx_q.size();
        push_word(32'hDEAD_BEEF);
        push_word(32'h0123_4567);
        push_word(32'h89AB_CDEF);
        wait_idle("uart", 1500);
        repeat (60) tick();
        exp_q = '{8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                  8'hA5, 8'h67, 8'h45, 8'h23, 8'h01,
                  8'hA5, 8'hEF, 8'hCD, 8'hAB, 8'h89};
        cmp_stream("uart", 2, base_rx);

        // reset in the middle of the second byte on the line
        base = mon_q.size();
        push_word(32'hCAFE_F00D);
        n = 0;
        while (mon_q.size() < base + 2 && n < 200) begin tick(); n++; end
        chk("mid_second_byte_started", 64'(mon_q.size() - base), 64'd2);
        repeat (10) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_fifo_count", 64'(fifo_count), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_tx_line", 64'(tx_line), 64'd1);
        tick(); tick();
        rst = 1'b0;
        repeat (200) tick();
        chk("post_rst_no_xfer", 64'(mon_q.size() - base), 64'd2);
        chk("post_rst_rx_len", 64'(rx_q.size() - base_rx), 64'd16);
        chk("post_rst_rx_last", 64'(rx_q[rx_q.size()-1]), 64'hA5);
        chk("post_rst_line_idle", 64'(tx_line), 64'd1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
